// File: rtl/toaplan_bus_pkg.sv
// Shared definitions for the 68000 bus region decoder.
//   - bus_state_t    : bus-cycle FSM states
//   - DEF_*          : default values for the decoder parameters
//   - region_entry_t : one decode-table entry
//   - region_mask()  : compare mask for a given ignored-low-bit count
// Entries hold base and wait count at fixed container widths
// (ENTRY_ADDR_W / ENTRY_WAIT_W). This lets the record live here without
// depending on the decoder's parameters. The decoder supports ADDR_W up
// to 32 and WAIT_W up to 16.
package toaplan_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_MISS,
    ST_HOLD
  } bus_state_t;

  localparam int DEF_NUM_REGIONS = 24;
  localparam int DEF_ADDR_W      = 24;
  localparam int DEF_WAIT_W      = 4;
  localparam int DEF_BERR_CYCLES = 255;

  localparam int ENTRY_ADDR_W = 32;
  localparam int ENTRY_WAIT_W = 16;

  typedef struct packed {
    logic                    en;
    logic [4:0]              width;
    logic [ENTRY_WAIT_W-1:0] wait_states;
    logic [ENTRY_ADDR_W-1:0] base;
  } region_entry_t;

  // Ones above bit 'width'. The low ADDR_W bits of this mask are all zero
  // once width >= ADDR_W, so such an entry matches every address without
  // a special case.
  function automatic logic [ENTRY_ADDR_W-1:0] region_mask(input logic [4:0] width);
    return {ENTRY_ADDR_W{1'b1}} << width;
  endfunction

endpackage

// File: rtl/region_match.sv
// Combinational priority matcher for the region decode table.
// Ports:
//   table_in    : decode table, one region_entry_t per region
//   cpu_a       : CPU address being decoded
//   hit         : at least one enabled entry matches cpu_a
//   idx         : lowest matching entry index (0 when no hit)
//   wait_states : wait count of that entry (0 when no hit)
module region_match
  import toaplan_bus_pkg::*;
#(
  parameter int NUM_REGIONS = DEF_NUM_REGIONS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int IDX_W       = $clog2(NUM_REGIONS)
) (
  input  region_entry_t           table_in [NUM_REGIONS],
  input  logic [ADDR_W-1:0]       cpu_a,
  output logic                    hit,
  output logic [IDX_W-1:0]        idx,
  output logic [ENTRY_WAIT_W-1:0] wait_states
);

  logic [NUM_REGIONS-1:0]  match_vec;
  logic [ENTRY_ADDR_W-1:0] addr_ext;

  assign addr_ext = ENTRY_ADDR_W'(cpu_a);

  generate
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_entry
      logic [ENTRY_ADDR_W-1:0] mask;
      assign mask          = region_mask(table_in[gi].width);
      assign match_vec[gi] = table_in[gi].en &&
                             (((addr_ext ^ table_in[gi].base) & mask) == '0);
    end
  endgenerate

  // Scan from the top down so the lowest matching index wins.
  always_comb begin
    hit         = 1'b0;
    idx         = '0;
    wait_states = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        hit         = 1'b1;
        idx         = IDX_W'(i);
        wait_states = table_in[i].wait_states;
      end
    end
  end

endmodule

// File: rtl/m68k_region_decoder.sv
// 68000 bus region decoder.
// The decoder holds a programmable table of address regions. It decodes
// each address-strobe cycle into a registered one-hot chip select, then
// generates DTACK after the region's wait states. A strobe that hits no
// region gets BERR after a timeout.
// Ports:
//   clk, reset_n    : clock (rising edge), asynchronous active-low reset
//   cfg_we/cfg_idx  : table write strobe and entry index (out of range ignored)
//   cfg_base/width/wait/en : entry contents
//   cpu_a, cpu_as_n : CPU address and active-low address strobe
//   cs, cs_idx, cs_valid   : registered chip select, its index, select valid
//   dtack_n, berr_n : active-low data acknowledge and bus error
module m68k_region_decoder
  import toaplan_bus_pkg::*;
#(
  parameter int NUM_REGIONS = DEF_NUM_REGIONS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_W      = DEF_WAIT_W,
  parameter int BERR_CYCLES = DEF_BERR_CYCLES,
  parameter int IDX_W       = $clog2(NUM_REGIONS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [ADDR_W-1:0]      cfg_base,
  input  logic [4:0]             cfg_width,
  input  logic [WAIT_W-1:0]      cfg_wait,
  input  logic                   cfg_en,
  input  logic [ADDR_W-1:0]      cpu_a,
  input  logic                   cpu_as_n,
  output logic [NUM_REGIONS-1:0] cs,
  output logic [IDX_W-1:0]       cs_idx,
  output logic                   cs_valid,
  output logic                   dtack_n,
  output logic                   berr_n
);

  localparam int MISS_CNT_W = $clog2(BERR_CYCLES + 1);

  region_entry_t table_reg [NUM_REGIONS];

  logic                    match_hit;
  logic [IDX_W-1:0]        match_idx;
  logic [ENTRY_WAIT_W-1:0] match_wait;

  bus_state_t              state_reg;
  logic                    armed_reg;
  logic [IDX_W-1:0]        sel_idx_reg;
  logic [ENTRY_WAIT_W-1:0] wait_cnt_reg;
  logic [MISS_CNT_W-1:0]   miss_cnt_reg;
  logic [NUM_REGIONS-1:0]  cs_reg;
  logic [IDX_W-1:0]        cs_idx_reg;
  logic                    cs_valid_reg;
  logic                    dtack_n_reg;
  logic                    berr_n_reg;

  // Decode table. An index at or beyond NUM_REGIONS compares equal to no
  // entry, so that write is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        table_reg[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          table_reg[i] <= '{en:          cfg_en,
                            width:       cfg_width,
                            wait_states: ENTRY_WAIT_W'(cfg_wait),
                            base:        ENTRY_ADDR_W'(cfg_base)};
        end
      end
    end
  end

  region_match #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .IDX_W       (IDX_W)
  ) u_match (
    .table_in    (table_reg),
    .cpu_a       (cpu_a),
    .hit         (match_hit),
    .idx         (match_idx),
    .wait_states (match_wait)
  );

  // Bus-cycle FSM. The decode result is captured in IDLE. After that, the
  // cycle runs only from the latched index and counts, so rewriting the
  // table mid-cycle cannot disturb it.
  // armed_reg records that the strobe has been seen high since the last
  // decode. A strobe held low across reset or a completed cycle therefore
  // never starts a second decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      armed_reg    <= 1'b0;
      sel_idx_reg  <= '0;
      wait_cnt_reg <= '0;
      miss_cnt_reg <= '0;
      cs_reg       <= '0;
      cs_idx_reg   <= '0;
      cs_valid_reg <= 1'b0;
      dtack_n_reg  <= 1'b1;
      berr_n_reg   <= 1'b1;
    end else begin
      if (cpu_as_n) begin
        armed_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (!cpu_as_n && armed_reg) begin
            armed_reg    <= 1'b0;
            sel_idx_reg  <= match_idx;
            wait_cnt_reg <= match_wait;
            miss_cnt_reg <= '0;
            state_reg    <= match_hit ? ST_WAIT : ST_MISS;
          end
        end

        ST_WAIT: begin
          if (cpu_as_n) begin
            // Aborted cycle: drop everything on this edge.
            cs_reg       <= '0;
            cs_idx_reg   <= '0;
            cs_valid_reg <= 1'b0;
            state_reg    <= ST_IDLE;
          end else begin
            // Select comes up on the first WAIT edge. DTACK follows when the
            // count has run out, so a zero-wait region acks on that same edge.
            cs_reg       <= NUM_REGIONS'(1) << sel_idx_reg;
            cs_idx_reg   <= sel_idx_reg;
            cs_valid_reg <= 1'b1;
            if (wait_cnt_reg == '0) begin
              dtack_n_reg <= 1'b0;
              state_reg   <= ST_ACK;
            end else begin
              wait_cnt_reg <= wait_cnt_reg - 1'b1;
            end
          end
        end

        ST_ACK: begin
          if (cpu_as_n) begin
            cs_reg       <= '0;
            cs_idx_reg   <= '0;
            cs_valid_reg <= 1'b0;
            dtack_n_reg  <= 1'b1;
            state_reg    <= ST_IDLE;
          end
        end

        ST_MISS: begin
          if (cpu_as_n) begin
            state_reg <= ST_IDLE;
          end else if (miss_cnt_reg == MISS_CNT_W'(BERR_CYCLES)) begin
            berr_n_reg <= 1'b0;
            state_reg  <= ST_HOLD;
          end else begin
            miss_cnt_reg <= miss_cnt_reg + 1'b1;
          end
        end

        ST_HOLD: begin
          if (cpu_as_n) begin
            berr_n_reg <= 1'b1;
            state_reg  <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign cs       = cs_reg;
  assign cs_idx   = cs_idx_reg;
  assign cs_valid = cs_valid_reg;
  assign dtack_n  = dtack_n_reg;
  assign berr_n   = berr_n_reg;

endmodule
